// File: rtl/uart_rx_byte_pkg.sv
// Shared definitions for the UART byte receiver: FSM state encoding,
// default line settings and the clock-divider helper.
package uart_rx_byte_pkg;

  localparam int DEFAULT_BAUD       = 115200;
  localparam int DEFAULT_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // clk cycles per oversample tick, truncated, never below 1
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    int d;
    d = clk_hz / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_byte_baud_tick_gen.sv
// Oversample tick generator: free-running counter wrapping at DIV-1,
// tick is high for the one clk in which the counter wraps.
module baud_tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == LAST);

  // divide counter, wraps on the tick cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_byte.sv
// UART receiver, 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
// Delivers bytes over valid/ready and pulses framing/parity/overrun flags.
module uart_rx_byte
  import uart_rx_byte_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = DEFAULT_BAUD,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       overrun_o
);

  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST    = TW'(OVERSAMPLE - 1);

  logic            tick;
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic [1:0]      sync_vld_q;
  logic            fall_edge_d;
  rx_state_e       state_q;
  logic [TW-1:0]   tick_cnt_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic [7:0]      data_q;
  logic            valid_q;
  logic            frame_err_q;
  logic            overrun_q;
`ifdef UART_RX_PARITY_EN
  logic            par_bit_q;
  logic            parity_err_q;
  logic            par_bad_d;
  // even parity: the parity bit must equal the XOR of the data bits
  assign par_bad_d    = par_bit_q ^ (^shift_q);
  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

  baud_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Synchronizer values only count once two real samples have passed
  // through, so a line held low across reset never looks like a start.
  assign fall_edge_d = sync_vld_q[1] & rx_prev_q & ~rx_sync_q;

  // two-flop synchronizer plus previous-sample register for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      sync_vld_q <= 2'b00;
      rx_prev_q  <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      sync_vld_q <= {sync_vld_q[0], 1'b1};
      rx_prev_q  <= sync_vld_q[1] & rx_sync_q;
    end
  end

  // frame FSM, shift register, handshake and registered error pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      // consumption first; a delivery in the same cycle overrides it below
      if (valid_q && ready_i) valid_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (fall_edge_d) begin
            tick_cnt_q <= '0;
            state_q    <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            if (tick_cnt_q == HALF_M1) begin
              tick_cnt_q <= '0;
              bit_cnt_q  <= '0;
              state_q    <= rx_sync_q ? ST_IDLE : ST_DATA;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (tick_cnt_q == LAST) begin
              tick_cnt_q <= '0;
              shift_q    <= {rx_sync_q, shift_q[7:1]};
              bit_cnt_q  <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state_q <= ST_PARITY;
`else
                state_q <= ST_STOP;
`endif
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            if (tick_cnt_q == LAST) begin
              tick_cnt_q <= '0;
              par_bit_q  <= rx_sync_q;
              state_q    <= ST_STOP;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            if (tick_cnt_q == LAST) begin
              // back to IDLE at mid-stop so a following start edge is caught
              tick_cnt_q <= '0;
              state_q    <= ST_IDLE;
              if (!rx_sync_q) begin
                frame_err_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
              end else if (par_bad_d) begin
                parity_err_q <= 1'b1;
`endif
              end else if (valid_q && !ready_i) begin
                overrun_q <= 1'b1;
              end else begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte: stimulus pushes expected bytes and
// error events into queues; a negedge monitor pops and compares.
module tb_uart_rx_byte;

  localparam int BIT_CLK = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int EV_FRAME   = 1;
  localparam int EV_PARITY  = 2;
  localparam int EV_OVERRUN = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ready_i = 1'b1;
  logic [7:0] data_o;
  logic       valid_o, frame_err_o, parity_err_o, overrun_o;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int frame_start_cyc = 0;
  int valid_rise_cyc = 0;
  int valid_hi_cnt = 0;
  bit model_hold = 1'b0;

  logic [7:0] exp_bytes[$];
  int         exp_err[$];

  uart_rx_byte #(
    .CLK_HZ(1_843_200), .BAUD(115200), .OVERSAMPLE(16)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .frame_err_o(frame_err_o), .parity_err_o(parity_err_o),
    .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    end else begin
      $display("[TB] ok %s = 0x%0h", name, act);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // reference outcome of one complete frame, from the line-level rules
  task automatic model_frame(input logic [7:0] d, input bit stop_bit, input bit par_ok);
    if (!stop_bit) exp_err.push_back(EV_FRAME);
    else if (PAR_EN && !par_ok) exp_err.push_back(EV_PARITY);
    else if (model_hold) exp_err.push_back(EV_OVERRUN);
    else begin
      exp_bytes.push_back(d);
      if (!ready_i) model_hold = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_bit, input bit par_ok);
    model_frame(d, stop_bit, par_ok);
    frame_start_cyc = cyc;
    rx = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clk(BIT_CLK);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ (!par_ok);
    wait_clk(BIT_CLK);
`endif
    rx = stop_bit;
    wait_clk(BIT_CLK);
    rx = 1'b1;
  endtask

  task automatic send_partial(input logic [7:0] d, input int nbits);
    rx = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < nbits; i++) begin
      rx = d[i];
      wait_clk(BIT_CLK);
    end
    rx = d[nbits];
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_bytes.size() + exp_err.size()) != 0 && n < 600) begin
      wait_clk(1);
      n++;
    end
    check("queues_drained", exp_bytes.size() + exp_err.size(), 0);
  endtask

  task automatic handle_err(input int kind);
    int e;
    if (exp_err.size() == 0) begin
      check("unexpected_error_event", kind, 0);
    end else begin
      e = exp_err.pop_front();
      check("error_event_kind", kind, e);
    end
  endtask

  // monitor: compares every delivered byte and every error pulse
  initial begin
    logic       v_prev = 1'b0, r_prev = 1'b0;
    logic [7:0] d_prev = '0;
    logic       fe_prev = 1'b0, pe_prev = 1'b0, ov_prev = 1'b0;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (valid_o) valid_hi_cnt++;
        if (valid_o && !v_prev) valid_rise_cyc = cyc;
        if (v_prev && !r_prev && valid_o) check("data_stable", data_o, d_prev);
        if (valid_o && ready_i) begin
          if (exp_bytes.size() == 0) begin
            check("unexpected_byte", {24'd0, data_o}, 32'h100);
          end else begin
            e = exp_bytes.pop_front();
            check("byte", data_o, e);
          end
        end
        if (frame_err_o) handle_err(EV_FRAME);
        if (parity_err_o) handle_err(EV_PARITY);
        if (overrun_o) handle_err(EV_OVERRUN);
        if (frame_err_o && fe_prev) check("frame_err_width", 2, 1);
        if (parity_err_o && pe_prev) check("parity_err_width", 2, 1);
        if (overrun_o && ov_prev) check("overrun_width", 2, 1);
      end
      v_prev = valid_o; r_prev = ready_i; d_prev = data_o;
      fe_prev = frame_err_o; pe_prev = parity_err_o; ov_prev = overrun_o;
    end
  end

  initial begin
    int hi0;
    int gap;
    logic [7:0] d;
    bit stop_b, par_b;

    rst = 1'b1; rx = 1'b1; ready_i = 1'b1;
    wait_clk(4);
    check("reset_data", data_o, 8'h00);
    check("reset_valid", valid_o, 1'b0);
    check("reset_frame_err", frame_err_o, 1'b0);
    check("reset_parity_err", parity_err_o, 1'b0);
    check("reset_overrun", overrun_o, 1'b0);
    rst = 1'b0;
    wait_clk(2 * BIT_CLK);

    // single good frame, latency and one-cycle valid with ready high
    hi0 = valid_hi_cnt;
    send_frame(8'hA5, 1'b1, 1'b1);
    wait_clk(BIT_CLK);
    drain();
    check("a5_latency_in_range",
          ((valid_rise_cyc - frame_start_cyc) >= 150 && (valid_rise_cyc - frame_start_cyc) <= 160) ? 1 : 0, 1);
    check("a5_valid_width", valid_hi_cnt - hi0, 1);

    // back-to-back with ready low: second byte overruns
    ready_i = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b1);
    send_frame(8'hC3, 1'b1, 1'b1);
    wait_clk(BIT_CLK);
    check("ovr_valid_held", valid_o, 1'b1);
    check("ovr_data_kept", data_o, 8'h3C);
    check("ovr_pulse_seen", exp_err.size(), 0);
    ready_i = 1'b1;
    model_hold = 1'b0;
    wait_clk(2);
    check("ovr_valid_cleared", valid_o, 1'b0);
    drain();

    // framing error, then a good frame
    send_frame(8'h55, 1'b0, 1'b1);
    wait_clk(2 * BIT_CLK);
    check("ferr_no_valid", valid_o, 1'b0);
    send_frame(8'h12, 1'b1, 1'b1);
    wait_clk(BIT_CLK);
    drain();

    // short glitch while idle is a false start
    hi0 = valid_hi_cnt;
    rx = 1'b0;
    wait_clk(4);
    rx = 1'b1;
    wait_clk(3 * BIT_CLK);
    check("glitch_no_valid", valid_hi_cnt - hi0, 0);
    check("glitch_no_events", exp_bytes.size() + exp_err.size(), 0);
    send_frame(8'h6E, 1'b1, 1'b1);
    wait_clk(BIT_CLK);
    drain();

    // reset in the middle of bit 4
    send_partial(8'hFF, 4);
    wait_clk(BIT_CLK / 2);
    rst = 1'b1;
    wait_clk(1);
    check("midrst_data", data_o, 8'h00);
    check("midrst_valid", valid_o, 1'b0);
    check("midrst_flags", {frame_err_o, parity_err_o, overrun_o}, 3'b000);
    wait_clk(2);
    rst = 1'b0;
    rx = 1'b1;
    hi0 = valid_hi_cnt;
    wait_clk(8 * BIT_CLK);
    check("midrst_no_delivery", valid_hi_cnt - hi0, 0);
    send_frame(8'h81, 1'b1, 1'b1);
    wait_clk(BIT_CLK);
    drain();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    wait_clk(2 * BIT_CLK);
    check("perr_no_valid", valid_o, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1);
    wait_clk(BIT_CLK);
    drain();
`endif

    // randomized frames with occasional stop/parity errors
    for (int i = 0; i < 24; i++) begin
      d      = 8'($urandom);
      stop_b = ($urandom_range(0, 5) != 0);
      par_b  = ($urandom_range(0, 4) != 0);
      send_frame(d, stop_b, par_b);
      gap = stop_b ? $urandom_range(0, 20) : $urandom_range(4, 20);
      wait_clk(gap);
    end
    wait_clk(BIT_CLK);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
